// File: rtl/mult_pkg.sv
// mult_pkg: widths shared by the Booth radix-4 Wallace multiplier and its final CPA stage.
package mult_pkg;

    localparam int PROD_W    = 32;
    localparam int OPND_W    = 16;
    localparam int CPA_SPLIT = 16;

    typedef logic [PROD_W-1:0] prod_t;

endpackage : mult_pkg

// File: rtl/cpa_slice.sv
// cpa_slice: combinational WIDTH-bit ripple slice of the carry-propagate adder, {o_cout, o_sum} = a + b + cin.
module cpa_slice #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // Widen every operand to WIDTH+1 so the carry-out lands in the top bit.
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule : cpa_slice

// File: rtl/wallace_cpa_pipe.sv
// wallace_cpa_pipe: two-stage pipelined CPA resolving the Wallace tree's sum/carry vectors into the product.
// Optional: define CPA_COUT_EN to add port cout, the registered carry-out of the high slice.
module wallace_cpa_pipe
    import mult_pkg::*;
#(
    parameter int W     = PROD_W,
    parameter int SPLIT = CPA_SPLIT
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] sum_vec,
    input  logic [W-1:0] carry_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] product
`ifdef CPA_COUT_EN
    ,
    output logic         cout
`endif
);

    localparam int HI_W = W - SPLIT;

    logic              r_s1_valid;
    logic [SPLIT-1:0]  r_lo;
    logic              r_c_lo;
    logic [HI_W-1:0]   r_sum_hi;
    logic [HI_W-1:0]   r_carry_hi;
    logic              r_s2_valid;
    logic [W-1:0]      r_product;

    logic              w_s2_ready;
    logic              w_in_fire;
    logic              w_s12_fire;
    logic [SPLIT-1:0]  w_lo;
    logic              w_c_lo;
    logic [HI_W-1:0]   w_hi;

    // out_ready reaches in_ready combinationally on purpose: no skid buffer between the stages.
    assign w_s2_ready = ~r_s2_valid | out_ready;
    assign in_ready   = ~r_s1_valid | w_s2_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_s12_fire = r_s1_valid & w_s2_ready;

    cpa_slice #(.WIDTH(SPLIT)) u_lo_slice (
        .i_a    (sum_vec[SPLIT-1:0]),
        .i_b    (carry_vec[SPLIT-1:0]),
        .i_cin  (1'b0),
        .o_sum  (w_lo),
        .o_cout (w_c_lo)
    );

`ifdef CPA_COUT_EN
    logic w_c_hi;
    logic r_cout;
`else
    logic w_unused_c_hi;
`endif

    cpa_slice #(.WIDTH(HI_W)) u_hi_slice (
        .i_a    (r_sum_hi),
        .i_b    (r_carry_hi),
        .i_cin  (r_c_lo),
        .o_sum  (w_hi),
`ifdef CPA_COUT_EN
        .o_cout (w_c_hi)
`else
        .o_cout (w_unused_c_hi)
`endif
    );

    // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values,
    // which is what lets input accept, s1->s2 transfer and output handshake happen on one edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: data registers are cleared too, so product reads 0 until the first load.
            r_s1_valid <= 1'b0;
            r_lo       <= '0;
            r_c_lo     <= 1'b0;
            r_sum_hi   <= '0;
            r_carry_hi <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_lo       <= w_lo;
                r_c_lo     <= w_c_lo;
                r_sum_hi   <= sum_vec[W-1:SPLIT];
                r_carry_hi <= carry_vec[W-1:SPLIT];
            end else if (w_s12_fire) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s2_valid <= 1'b0;
            r_product  <= '0;
        end else begin
            if (w_s12_fire) begin
                r_s2_valid <= 1'b1;
                r_product  <= {w_hi, r_lo};
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

`ifdef CPA_COUT_EN
    // Carry-out travels with its product; a legal operand pair never sets it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cout <= 1'b0;
        end else if (w_s12_fire) begin
            r_cout <= w_c_hi;
        end
    end

    assign cout = r_cout;
`endif

    assign out_valid = r_s2_valid;
    assign product   = r_product;

endmodule : wallace_cpa_pipe

// File: tb/tb_wallace_cpa_pipe.sv
// tb_wallace_cpa_pipe: scoreboard bench for wallace_cpa_pipe; build with CPA_COUT_EN defined to cover cout.
module tb_wallace_cpa_pipe;
    import mult_pkg::*;

    typedef struct {
        prod_t prod;
        logic  cout;
        int    cyc;
    } exp_t;

    logic  sys_clk;
    logic  sys_rst_n;
    logic  in_valid;
    logic  in_ready;
    prod_t sum_vec;
    prod_t carry_vec;
    logic  out_valid;
    logic  out_ready;
    prod_t product;
`ifdef CPA_COUT_EN
    logic  cout;
`endif

    int    n_tests   = 0;
    int    n_fail    = 0;
    int    cyc       = 0;
    bit    check_lat = 1'b0;
    exp_t  sb[$];

    wallace_cpa_pipe #(.W(PROD_W), .SPLIT(CPA_SPLIT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
`ifdef CPA_COUT_EN
        ,
        .cout      (cout)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    // Scoreboard: handshakes are decided before the coming edge, so observe them on the falling edge.
    always @(negedge sys_clk) begin
        exp_t e;
        logic [PROD_W:0] full;
        if (sys_rst_n && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: product=%h appeared, required no output", product);
            end else begin
                e = sb.pop_front();
                if (product !== e.prod) begin
                    n_fail++;
                    $display("FAIL sb_product: got %h, required %h", product, e.prod);
                end
`ifdef CPA_COUT_EN
                n_tests++;
                if (cout !== e.cout) begin
                    n_fail++;
                    $display("FAIL sb_cout: got %b, required %b", cout, e.cout);
                end
`endif
                if (check_lat) begin
                    n_tests++;
                    if (cyc - e.cyc != 2) begin
                        n_fail++;
                        $display("FAIL sb_latency: got %0d cycles, required 2", cyc - e.cyc);
                    end
                end
            end
        end
        if (sys_rst_n && in_valid && in_ready) begin
            full   = {1'b0, sum_vec} + {1'b0, carry_vec};
            e.prod = full[PROD_W-1:0];
            e.cout = full[PROD_W];
            e.cyc  = cyc;
            sb.push_back(e);
        end
    end

    // Present one input and return one cycle after it is accepted (just after that edge).
    task automatic send(input prod_t s, input prod_t c);
        int budget;
        sum_vec   = s;
        carry_vec = c;
        in_valid  = 1'b1;
        budget    = 0;
        while (!in_ready && budget < 50) begin
            @(posedge sys_clk); #1;
            budget++;
        end
        if (budget >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, budget);
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while ((sb.size() != 0 || out_valid) && budget < 20) begin
            @(posedge sys_clk); #1;
            budget++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_vec   = '0;
        carry_vec = '0;
        #12;
        n_tests++;
        if (out_valid !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset_out: out_valid=%b product=%h, required 0/00000000", out_valid, product);
        end
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b product=%h, required 1/0/00000000",
                     in_ready, out_valid, product);
        end
    endtask

    task automatic test_directed(input string name, input prod_t s, input prod_t c,
                                 input prod_t exp_p, input logic exp_c);
        check_lat = 1'b1;
        out_ready = 1'b1;
        send(s, c);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early: out_valid=%b one cycle after accept, required 0", name, out_valid);
        end
        @(posedge sys_clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || product !== exp_p) begin
            n_fail++;
            $display("FAIL %s: out_valid=%b product=%h, required 1/%h", name, out_valid, product, exp_p);
        end
`ifdef CPA_COUT_EN
        n_tests++;
        if (cout !== exp_c) begin
            n_fail++;
            $display("FAIL %s_cout: got %b, required %b", name, cout, exp_c);
        end
`else
        if (exp_c === 1'bx) $display("%s: unexpected unknown cout expectation", name);
`endif
        drain();
    endtask

    task automatic test_backpressure();
        check_lat = 1'b0;
        out_ready = 1'b0;
        send(32'h10, 32'h01);
        send(32'h20, 32'h02);
        sum_vec   = 32'h30;
        carry_vec = 32'h03;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b after second accept, required 0", in_ready);
        end
        repeat (3) begin @(posedge sys_clk); #1; end
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || product !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b product=%h, required 0/1/00000011",
                     in_ready, out_valid, product);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_release_%0d: out_valid=%b, required 1", i, out_valid);
            end
            @(posedge sys_clk); #1;
            in_valid = 1'b0;
        end
        drain();
    endtask

    task automatic test_streaming();
        int ready_bad;
        check_lat = 1'b1;
        out_ready = 1'b1;
        ready_bad = 0;
        for (int i = 0; i < 100; i++) begin
            sum_vec   = $urandom();
            carry_vec = $urandom();
            in_valid  = 1'b1;
            if (!in_ready) ready_bad++;
            @(posedge sys_clk); #1;
        end
        n_tests++;
        if (ready_bad != 0) begin
            n_fail++;
            $display("FAIL stream_in_ready: low in %0d cycles, required 0", ready_bad);
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        int stale;
        check_lat = 1'b0;
        out_ready = 1'b0;
        send(32'hAAAA_0000, 32'h0000_5555);
        send(32'h1234_5678, 32'h1111_1111);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_fill: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: out_valid=%b product=%h, required 0/00000000", out_valid, product);
        end
        sb.delete();
        @(posedge sys_clk); #3;
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        repeat (5) begin
            @(posedge sys_clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL rst_mid_stale: out_valid high in %0d cycles, required 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_directed("split_carry", 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0);
        test_directed("max_square",  32'h3FFF_FFFF, 32'h0000_0001, 32'h4000_0000, 1'b0);
        test_directed("wrap",        32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        test_backpressure();
        test_streaming();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wallace_cpa_pipe
